fc_sram_writer: RTL and testbench
=================================

// Module: fc_sram_writer
// PURPOSE
//  Write-side counterpart of the FC-layer SRAM readers. Accepts a stream of FC results (one DATA_WIDTH
//  value per handshake), packs DATA_NUM_PER_SRAM_ADDR values per SRAM word, and writes the words
//  round-robin across the 5 SRAMs of the selected group (c, d or e). Sits between the FC datapath
//  output and the c/d/e SRAM write ports, so the next layer's reader gets a correctly laid-out window.
// PARAMETERS
//  DATA_WIDTH              8   bits per data element
//  DATA_NUM_PER_SRAM_ADDR  4   elements per SRAM word (lanes)
//  SRAM_NUM                5   SRAMs per group (c0..c4, d0..d4, e0..e4)
//  ADDR_WIDTH              10  SRAM address width
//  CNT_WIDTH               12  width of the element count
// PORTS
//  clk            in   1                             clock, rising edge
//  rst            in   1                             reset; asynchronous, active-high
//  start          in   1                             one-cycle pulse: begin a transfer (sampled in IDLE only)
//  sram_sel       in   2                             group: 0=c, 1=d, 2=e; sampled on start
//  base_addr      in   ADDR_WIDTH                    first row address; sampled on start
//  total_num      in   CNT_WIDTH                     elements in transfer; sampled on start
//  in_valid       in   1                             in_data valid
//  in_data        in   DATA_WIDTH                    result element
//  in_ready       out  1                             block accepts in_data this cycle
//  sram_wen       out  3*SRAM_NUM                    active-low write enables, bit g*SRAM_NUM+b = group g, SRAM b
//  sram_waddr     out  ADDR_WIDTH                    shared write address
//  sram_wdata     out  DATA_NUM_PER_SRAM_ADDR*DATA_WIDTH  shared write data
//  sram_bytemask  out  DATA_NUM_PER_SRAM_ADDR        active-low lane mask (0 = lane written)
//  busy           out  1                             high from accepted start until done
//  done           out  1                             one-cycle pulse after last write
// BEHAVIOUR
//  Reset (any time, incl. mid-transfer): state IDLE, sram_wen all 1, sram_waddr/sram_wdata 0,
//   sram_bytemask all 1, in_ready/busy/done 0, lane/bank/row/element counters 0. Partial data dropped.
//  FSM: IDLE -> PACK -> WRITE -> (PACK | FIN) ; FIN -> IDLE.
//   IDLE: start & sram_sel<3 & total_num>0 -> PACK, latch params, busy=1.
//         start & sram_sel<3 & total_num==0 -> FIN (no writes). start & sram_sel==3 -> ignored.
//   PACK: in_ready=1. Accept on in_valid&in_ready; element k of a word goes to lane k; lane 0 occupies
//         the MSBs, i.e. bits [(N-k)*DATA_WIDTH-1 -: DATA_WIDTH], N=DATA_NUM_PER_SRAM_ADDR.
//         Go WRITE in the cycle after lane N-1 is accepted or after the last element (count==total_num).
//   WRITE: exactly one cycle; in_ready=0; sram_wen bit (sel*SRAM_NUM+bank) = 0, others 1;
//         sram_waddr = base_addr + row (mod 2^ADDR_WIDTH); sram_bytemask bit (N-1-k) = 0 for filled lanes,
//         1 for unfilled lanes (unfilled lane data = 0). Then bank++; bank wraps SRAM_NUM-1 -> 0 with row++.
//         -> FIN if all elements written, else PACK with lane counter cleared.
//   FIN: done=1 for one cycle, busy drops with it; -> IDLE.
//  Outside WRITE: sram_wen all 1, sram_bytemask all 1; sram_waddr/sram_wdata hold last value.
//  Latency: write strobe appears 1 cycle after the accept of the word's last lane; steady-state
//   throughput N elements per N+1 cycles. done 1 cycle after final WRITE.
//  start while busy is ignored; input params may change freely after start. in_valid while not
//   in_ready is ignored (not consumed). Element counter saturates at total_num; no extra accepts.
//  Addition base_addr+row is ADDR_WIDTH bits, wraps silently.
// TESTING
//  1 reset: assert rst mid-WRITE -> same cycle sram_wen=15'h7FFF, busy=0; after release no write occurs.
//  2 full words: sel=1, base=0x010, total=20, data 1..20 back-to-back -> 5 writes to d0..d4 at 0x010,
//    wdata d0=0x01020304 .. d4=0x11121314, bytemask 4'h0, done one cycle after 5th write.
//  3 wrap/partial: sel=0, base=0x3FF, total=22 -> c0..c4 at 0x3FF, then c0 at 0x000 with
//    wdata 0x15160000, bytemask 4'b0011; busy then done.
//  4 backpressure: in_valid toggled randomly, total=8 -> in_ready=0 in each WRITE cycle, no element
//    lost or duplicated, writes c0=0x01020304, c1=0x05060708.
//  5 corner starts: total_num=0 -> done next-next cycle, no wen; sram_sel=3 -> no busy/done;
//    start pulse during busy -> ignored, original transfer completes unchanged.

Source files
------------

// File: rtl/fc_sram_writer_if.sv
// Stream-in / SRAM-write-out signal bundle for fc_sram_writer.
// master = the side that issues start and streams data; slave = the writer itself.
interface fc_sram_writer_if #(
   parameter int DATA_WIDTH             = 8,
   parameter int DATA_NUM_PER_SRAM_ADDR = 4,
   parameter int SRAM_NUM               = 5,
   parameter int ADDR_WIDTH             = 10,
   parameter int CNT_WIDTH              = 12
);
   logic                                        start;
   logic [1:0]                                  sram_sel;
   logic [ADDR_WIDTH-1:0]                       base_addr;
   logic [CNT_WIDTH-1:0]                        total_num;
   logic                                        in_valid;
   logic [DATA_WIDTH-1:0]                       in_data;
   logic                                        in_ready;
   logic [3*SRAM_NUM-1:0]                       sram_wen;
   logic [ADDR_WIDTH-1:0]                       sram_waddr;
   logic [DATA_NUM_PER_SRAM_ADDR*DATA_WIDTH-1:0] sram_wdata;
   logic [DATA_NUM_PER_SRAM_ADDR-1:0]           sram_bytemask;
   logic                                        busy;
   logic                                        done;

   modport master (
      output start, sram_sel, base_addr, total_num, in_valid, in_data,
      input  in_ready, sram_wen, sram_waddr, sram_wdata, sram_bytemask, busy, done
   );

   modport slave (
      input  start, sram_sel, base_addr, total_num, in_valid, in_data,
      output in_ready, sram_wen, sram_waddr, sram_wdata, sram_bytemask, busy, done
   );
endinterface

// File: rtl/fc_sram_writer.sv
// Packs a stream of FC results into SRAM words and writes them round-robin
// across the five SRAMs of the selected c/d/e group, advancing the row every SRAM_NUM words.
module fc_sram_writer #(
   parameter int DATA_WIDTH             = 8,
   parameter int DATA_NUM_PER_SRAM_ADDR = 4,
   parameter int SRAM_NUM               = 5,
   parameter int ADDR_WIDTH             = 10,
   parameter int CNT_WIDTH              = 12
) (
   input  logic            clk,
   input  logic            rst,
   fc_sram_writer_if.slave bus
);
   localparam int N      = DATA_NUM_PER_SRAM_ADDR;
   localparam int WORD_W = N * DATA_WIDTH;
   localparam int LANE_W = $clog2(N + 1);
   localparam int BANK_W = (SRAM_NUM > 1) ? $clog2(SRAM_NUM) : 1;
   localparam int WEN_W  = 3 * SRAM_NUM;
   localparam int WIDX_W = $clog2(WEN_W);

   typedef enum logic [1:0] {IDLE, PACK, WRITE, FIN} state_t;

   state_t                state_reg, state_next;
   logic [1:0]            sel_reg;
   logic [ADDR_WIDTH-1:0] base_reg;
   logic [CNT_WIDTH-1:0]  total_reg;
   logic [CNT_WIDTH-1:0]  count_reg;
   logic [LANE_W-1:0]     lane_reg;
   logic [BANK_W-1:0]     bank_reg;
   logic [ADDR_WIDTH-1:0] row_reg;
   logic [WORD_W-1:0]     word_reg;
   logic [ADDR_WIDTH-1:0] waddr_reg;
   logic [WORD_W-1:0]     wdata_reg;

   logic                  start_ok;
   logic                  accept;
   logic                  word_full;
   logic                  last_elem;
   logic [ADDR_WIDTH-1:0] cur_addr;
   logic [WIDX_W-1:0]     wen_idx;

   assign start_ok  = bus.start && (bus.sram_sel != 2'd3);
   assign accept    = (state_reg == PACK) && bus.in_valid;
   assign word_full = (lane_reg == LANE_W'(N - 1));
   assign last_elem = (CNT_WIDTH'(count_reg + 1'b1) == total_reg);
   assign cur_addr  = base_reg + row_reg;
   assign wen_idx   = WIDX_W'(sel_reg) * WIDX_W'(SRAM_NUM) + WIDX_W'(bank_reg);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (start_ok) state_next = (bus.total_num == '0) ? FIN : PACK;
         PACK: if (accept && (word_full || last_elem)) state_next = WRITE;
         WRITE: state_next = (count_reg == total_reg) ? FIN : PACK;
         FIN: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_reg   <= '0;
         base_reg  <= '0;
         total_reg <= '0;
         count_reg <= '0;
         lane_reg  <= '0;
         bank_reg  <= '0;
         row_reg   <= '0;
         word_reg  <= '0;
         waddr_reg <= '0;
         wdata_reg <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start_ok) begin
                  sel_reg   <= bus.sram_sel;
                  base_reg  <= bus.base_addr;
                  total_reg <= bus.total_num;
                  count_reg <= '0;
                  lane_reg  <= '0;
                  bank_reg  <= '0;
                  row_reg   <= '0;
                  word_reg  <= '0;
               end
            end
            PACK: begin
               if (accept) begin
                  // lane 0 sits in the most significant slot of the word
                  for (int k = 0; k < N; k++) begin
                     if (lane_reg == LANE_W'(k)) word_reg[(N-k)*DATA_WIDTH-1 -: DATA_WIDTH] <= bus.in_data;
                  end
                  lane_reg  <= lane_reg + 1'b1;
                  count_reg <= count_reg + 1'b1;
               end
            end
            WRITE: begin
               waddr_reg <= cur_addr;
               wdata_reg <= word_reg;
               word_reg  <= '0;
               lane_reg  <= '0;
               if (bank_reg == BANK_W'(SRAM_NUM - 1)) begin
                  bank_reg <= '0;
                  row_reg  <= row_reg + 1'b1;
               end else begin
                  bank_reg <= bank_reg + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // The hold registers keep address/data stable between write strobes.
   assign bus.sram_waddr = (state_reg == WRITE) ? cur_addr : waddr_reg;
   assign bus.sram_wdata = (state_reg == WRITE) ? word_reg : wdata_reg;
   assign bus.in_ready   = (state_reg == PACK);
   assign bus.busy       = (state_reg == PACK) || (state_reg == WRITE);
   assign bus.done       = (state_reg == FIN);

   genvar gi;
   generate
      for (gi = 0; gi < WEN_W; gi++) begin : g_wen
         assign bus.sram_wen[gi] = !((state_reg == WRITE) && (wen_idx == WIDX_W'(gi)));
      end
      for (gi = 0; gi < N; gi++) begin : g_mask
         assign bus.sram_bytemask[N-1-gi] = !((state_reg == WRITE) && (LANE_W'(gi) < lane_reg));
      end
   endgenerate
endmodule

// File: tb/tb_fc_sram_writer.sv
// Scoreboard bench for fc_sram_writer: expected writes are queued when a transfer
// is launched and compared as strobes appear on the SRAM port.
module tb_fc_sram_writer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fc_sram_writer_if bus ();
   fc_sram_writer dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      logic [14:0] wen;
      logic [9:0]  addr;
      logic [31:0] data;
      logic [3:0]  mask;
   } wr_t;

   wr_t exp_q[$];
   wr_t mon_e;
   int  vectors = 0;
   int  miscompares = 0;
   int  cyc = 0;
   int  last_wr_cyc = -10;
   int  wr_count = 0;
   bit  mon_en = 1'b1;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (mon_en && !rst && bus.sram_wen != 15'h7FFF) begin
         last_wr_cyc = cyc;
         wr_count++;
         if (exp_q.size() == 0) begin
            check_val("unexpected_write", {49'd0, bus.sram_wen}, 64'h7FFF);
         end else begin
            mon_e = exp_q.pop_front();
            check_val("wen", {49'd0, bus.sram_wen}, {49'd0, mon_e.wen});
            check_val("waddr", {54'd0, bus.sram_waddr}, {54'd0, mon_e.addr});
            check_val("wdata", {32'd0, bus.sram_wdata}, {32'd0, mon_e.data});
            check_val("bytemask", {60'd0, bus.sram_bytemask}, {60'd0, mon_e.mask});
            check_val("ready_in_write", {63'd0, bus.in_ready}, 64'd0);
         end
         $display("write wen=%h addr=%h data=%h mask=%b", bus.sram_wen, bus.sram_waddr,
                  bus.sram_wdata, bus.sram_bytemask);
      end
   end

   // Reference layout: element e (value e+1) -> word e/4, lane e%4; word w -> bank w%5, row w/5.
   task automatic push_expected(input int sel, input int base, input int total);
      wr_t e;
      logic [31:0] d;
      for (int w = 0; w * 4 < total; w++) begin
         d = 32'd0;
         e.mask = 4'hF;
         for (int k = 0; k < 4; k++) begin
            if (w * 4 + k < total) begin
               d[(4-k)*8-1 -: 8] = 8'(w * 4 + k + 1);
               e.mask[3-k] = 1'b0;
            end
         end
         e.data = d;
         e.wen  = ~(15'd1 << (sel * 5 + w % 5));
         e.addr = 10'(base + w / 5);
         exp_q.push_back(e);
      end
   endtask

   task automatic start_transfer(input int sel, input int base, input int total, input bit push);
      if (push) push_expected(sel, base, total);
      @(posedge clk); #1;
      bus.start = 1'b1;
      bus.sram_sel = 2'(sel);
      bus.base_addr = 10'(base);
      bus.total_num = 12'(total);
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.sram_sel = 2'($urandom);
      bus.base_addr = 10'($urandom);
      bus.total_num = 12'($urandom);
   endtask

   task automatic feed(input int total, input bit rnd);
      int  idx = 0;
      int  guard = 0;
      bit  acc;
      while (idx < total && guard < 500) begin
         bus.in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         bus.in_data  = 8'(idx + 1);
         @(negedge clk);
         acc = bus.in_valid && bus.in_ready;
         @(posedge clk); #1;
         if (acc) idx++;
         guard++;
      end
      bus.in_valid = 1'b0;
      bus.in_data  = 8'hEE;
      check_val("feed_complete", 64'(idx), 64'(total));
   endtask

   task automatic wait_done(input bit has_writes);
      int guard = 0;
      bit seen = 1'b0;
      while (!seen && guard < 50) begin
         @(negedge clk);
         seen = bus.done;
         guard++;
      end
      check_val("done_seen", {63'd0, seen}, 64'd1);
      if (seen) begin
         check_val("busy_at_done", {63'd0, bus.busy}, 64'd0);
         if (has_writes) check_val("done_latency", 64'(cyc - last_wr_cyc), 64'd1);
      end
      check_val("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      @(negedge clk);
      check_val("done_pulse", {63'd0, bus.done}, 64'd0);
   endtask

   initial begin
      int n;
      bit any;
      bus.start = 1'b0; bus.sram_sel = 2'd0; bus.base_addr = '0; bus.total_num = '0;
      bus.in_valid = 1'b0; bus.in_data = '0;

      // reset state
      repeat (3) @(negedge clk);
      check_val("rst_wen", {49'd0, bus.sram_wen}, 64'h7FFF);
      check_val("rst_mask", {60'd0, bus.sram_bytemask}, 64'hF);
      check_val("rst_waddr", {54'd0, bus.sram_waddr}, 64'd0);
      check_val("rst_wdata", {32'd0, bus.sram_wdata}, 64'd0);
      check_val("rst_busy_done_ready", {61'd0, bus.busy, bus.done, bus.in_ready}, 64'd0);
      @(posedge clk); #1 rst = 1'b0;

      // reset asserted during a WRITE cycle
      mon_en = 1'b0;
      start_transfer(0, 'h040, 8, 1'b0);
      feed(4, 1'b0);
      @(negedge clk);
      check_val("pre_rst_write", {63'd0, (bus.sram_wen != 15'h7FFF)}, 64'd1);
      rst = 1'b1;
      #1;
      check_val("midrst_wen", {49'd0, bus.sram_wen}, 64'h7FFF);
      check_val("midrst_busy", {63'd0, bus.busy}, 64'd0);
      @(posedge clk); #1 rst = 1'b0;
      bus.in_valid = 1'b1;
      n = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus.sram_wen != 15'h7FFF) n++;
      end
      bus.in_valid = 1'b0;
      check_val("post_rst_writes", 64'(n), 64'd0);
      mon_en = 1'b1;

      // full words to group d
      start_transfer(1, 'h010, 20, 1'b1);
      feed(20, 1'b0);
      wait_done(1'b1);

      // address wrap with a partial last word
      start_transfer(0, 'h3FF, 22, 1'b1);
      feed(22, 1'b0);
      wait_done(1'b1);

      // random backpressure
      start_transfer(0, 'h020, 8, 1'b1);
      feed(8, 1'b1);
      wait_done(1'b1);

      // empty transfer: done without any write
      n = wr_count;
      start_transfer(1, 'h055, 0, 1'b1);
      wait_done(1'b0);
      check_val("zero_total_writes", 64'(wr_count - n), 64'd0);

      // invalid group: ignored
      start_transfer(3, 'h000, 8, 1'b0);
      any = 1'b0;
      repeat (6) begin
         @(negedge clk);
         any = any | bus.busy | bus.done;
      end
      check_val("sel3_ignored", {63'd0, any}, 64'd0);

      // start while busy is ignored
      start_transfer(2, 'h100, 12, 1'b1);
      fork
         feed(12, 1'b1);
         begin
            repeat (3) @(posedge clk);
            #1;
            bus.start = 1'b1; bus.sram_sel = 2'd0; bus.base_addr = '0; bus.total_num = 12'd4;
            @(posedge clk); #1;
            bus.start = 1'b0;
         end
      join
      wait_done(1'b1);
      repeat (5) @(negedge clk);
      check_val("idle_after_busy_start", {63'd0, bus.busy}, 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end
endmodule
